// File: rtl/rgu_param.sv
// ---------------------------------------------------------------------------
// rgu_param - request generation unit for one mesh-router input port.
//
// Captures the destination address of a packet header on rqs_strobe and
// turns it into a one-hot output-port request using dimension-ordered
// routing (XY or YX) against this router's own coordinates. The request is
// held toward the output arbiter until arb_ack. A header that arrives
// together with arb_ack is accepted back-to-back; a header that arrives
// while a request is still waiting is dropped and flagged on rqs_overrun.
//
// Optional feature (compile-time macro RGU_ADAPTIVE_EN):
//   While waiting for arb_ack, the route is re-evaluated every cycle. When
//   both dimensions are productive and the dimension-order port is not
//   free but the other productive port is, the other port is requested.
//   Without the macro, port_free is ignored and the vector is fixed when
//   the header is latched.
//
// Parameters:
//   X_WIDTH, Y_WIDTH   coordinate widths inside addr
//   LOCAL_X, LOCAL_Y   this router's coordinates
//   ROUTE_MODE         0 = XY order, 1 = YX order
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   rqs_strobe   header valid; addr sampled this cycle
//   addr         destination, [X_WIDTH-1:0] = X, upper Y_WIDTH bits = Y
//   arb_ack      arbiter grant for the current request
//   port_free    per-direction availability {S,N,W,E} (adaptive only)
//   rqs_vector   one-hot request {S,N,W,E,local}
//   busy         request outstanding
//   rqs_overrun  one-cycle pulse: header dropped while busy
// ---------------------------------------------------------------------------
module rgu_param #(
  parameter int X_WIDTH    = 4,
  parameter int Y_WIDTH    = 4,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0,
  parameter int ROUTE_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rqs_strobe,
  input  logic [X_WIDTH+Y_WIDTH-1:0] addr,
  input  logic                       arb_ack,
  input  logic [3:0]                 port_free,
  output logic [4:0]                 rqs_vector,
  output logic                       busy,
  output logic                       rqs_overrun
);

  localparam int AW = X_WIDTH + Y_WIDTH;
  localparam logic [X_WIDTH-1:0] LX = X_WIDTH'(LOCAL_X);
  localparam logic [Y_WIDTH-1:0] LY = Y_WIDTH'(LOCAL_Y);

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_E     = 5'b00010;
  localparam logic [4:0] P_W     = 5'b00100;
  localparam logic [4:0] P_N     = 5'b01000;
  localparam logic [4:0] P_S     = 5'b10000;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  // Dimension-order route: the port a plain XY/YX router would pick.
  function automatic logic [4:0] route_dor(input logic [AW-1:0] a);
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [4:0]         xp;
    logic [4:0]         yp;
    x  = a[X_WIDTH-1:0];
    y  = a[AW-1:X_WIDTH];
    xp = (x > LX) ? P_E : P_W;
    yp = (y > LY) ? P_N : P_S;
    if ((x == LX) && (y == LY))
      route_dor = P_LOCAL;
    else if (ROUTE_MODE == 0)
      route_dor = (x != LX) ? xp : yp;
    else
      route_dor = (y != LY) ? yp : xp;
  endfunction

`ifdef RGU_ADAPTIVE_EN
  // Minimal-adaptive route: only ever swaps between the two productive
  // ports, and only when that moves from a blocked port to a free one.
  function automatic logic [4:0] route_adapt(input logic [AW-1:0] a,
                                             input logic [3:0]    pf);
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [4:0]         xp;
    logic [4:0]         yp;
    logic [4:0]         dor;
    logic [4:0]         alt;
    x   = a[X_WIDTH-1:0];
    y   = a[AW-1:X_WIDTH];
    xp  = (x > LX) ? P_E : P_W;
    yp  = (y > LY) ? P_N : P_S;
    dor = route_dor(a);
    alt = (ROUTE_MODE == 0) ? yp : xp;
    // Vector bits [4:1] line up with port_free {S,N,W,E}.
    if ((x != LX) && (y != LY) && ((dor[4:1] & pf) == 4'b0) &&
        ((alt[4:1] & pf) != 4'b0))
      route_adapt = alt;
    else
      route_adapt = dor;
  endfunction
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_addr_nxt;
  logic            r_overrun;
  logic            w_overrun_nxt;

`ifdef RGU_ADAPTIVE_EN
  logic [4:0]      r_vec;
  logic [4:0]      w_vec_nxt;
`else
  logic            w_unused_port_free;
  assign w_unused_port_free = ^port_free;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_overrun_nxt = 1'b0;
`ifdef RGU_ADAPTIVE_EN
    w_vec_nxt     = r_vec;
`endif
    case (r_state)
      IDLE: begin
        if (rqs_strobe) begin
          w_state_nxt = REQ;
          w_addr_nxt  = addr;
`ifdef RGU_ADAPTIVE_EN
          w_vec_nxt   = route_adapt(addr, port_free);
`endif
        end
      end
      REQ: begin
        if (arb_ack) begin
          if (rqs_strobe) begin
            // Back-to-back: the grant retires the old request and the new
            // header takes its place without passing through IDLE.
            w_addr_nxt = addr;
`ifdef RGU_ADAPTIVE_EN
            w_vec_nxt  = route_adapt(addr, port_free);
`endif
          end else begin
            w_state_nxt = IDLE;
`ifdef RGU_ADAPTIVE_EN
            w_vec_nxt   = 5'b0;
`endif
          end
        end else begin
          w_overrun_nxt = rqs_strobe;
`ifdef RGU_ADAPTIVE_EN
          w_vec_nxt     = route_adapt(r_addr, port_free);
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_overrun <= 1'b0;
`ifdef RGU_ADAPTIVE_EN
      r_vec     <= 5'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_overrun <= w_overrun_nxt;
`ifdef RGU_ADAPTIVE_EN
      r_vec     <= w_vec_nxt;
`endif
    end
  end

  assign busy        = (r_state == REQ);
  assign rqs_overrun = r_overrun;
`ifdef RGU_ADAPTIVE_EN
  assign rqs_vector  = r_vec;
`else
  // Route is a pure function of the latched address, gated by busy so the
  // vector is zero whenever no request is outstanding.
  assign rqs_vector  = busy ? route_dor(r_addr) : 5'b0;
`endif

endmodule

// File: tb/tb_rgu_param.sv
// ---------------------------------------------------------------------------
// tb_rgu_param - self-checking bench for rgu_param. Two instances share the
// stimulus: one XY-ordered and one YX-ordered, both at LOCAL=(2,1).
// ---------------------------------------------------------------------------
module tb_rgu_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rqs_strobe = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       arb_ack = 1'b0;
  logic [3:0] port_free = 4'b1111;

  logic [4:0] vec_xy, vec_yx;
  logic       busy_xy, busy_yx, ovr_xy, ovr_yx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rgu_param #(.X_WIDTH(4), .Y_WIDTH(4), .LOCAL_X(2), .LOCAL_Y(1), .ROUTE_MODE(0)) u_xy (
    .clk(clk), .rst(rst), .rqs_strobe(rqs_strobe), .addr(addr), .arb_ack(arb_ack),
    .port_free(port_free), .rqs_vector(vec_xy), .busy(busy_xy), .rqs_overrun(ovr_xy));

  rgu_param #(.X_WIDTH(4), .Y_WIDTH(4), .LOCAL_X(2), .LOCAL_Y(1), .ROUTE_MODE(1)) u_yx (
    .clk(clk), .rst(rst), .rqs_strobe(rqs_strobe), .addr(addr), .arb_ack(arb_ack),
    .port_free(port_free), .rqs_vector(vec_yx), .busy(busy_yx), .rqs_overrun(ovr_yx));

  typedef struct {
    logic [7:0] addr;
    logic [4:0] exy;
    logic [4:0] eyx;
  } vec_t;

  vec_t       tbl[8];
  logic [9:0] sb[$];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] e;
    logic [4:0] exp_ad;

    // {addr, XY expectation, YX expectation} with LOCAL=(2,1)
    tbl[0] = '{8'h15, 5'b00010, 5'b00010}; // X5 Y1: E in both orders
    tbl[1] = '{8'h12, 5'b00001, 5'b00001}; // local
    tbl[2] = '{8'h30, 5'b00100, 5'b01000}; // X0 Y3: W / N
    tbl[3] = '{8'h05, 5'b00010, 5'b10000}; // X5 Y0: E / S
    tbl[4] = '{8'h35, 5'b00010, 5'b01000}; // X5 Y3: E / N
    tbl[5] = '{8'h01, 5'b00100, 5'b10000}; // X1 Y0: W / S
    tbl[6] = '{8'hF2, 5'b01000, 5'b01000}; // X2 Y15: N
    tbl[7] = '{8'h02, 5'b10000, 5'b10000}; // X2 Y0: S

    // Reset state
    #12;
    chk("reset_vec", vec_xy, 5'b0);
    chk("reset_busy", {4'b0, busy_xy}, 5'b0);
    chk("reset_ovr", {4'b0, ovr_xy}, 5'b0);
    rst = 1'b1;
    tick();

    // Table-driven routes through the scoreboard
    for (int i = 0; i < 8; i++) begin
      rqs_strobe = 1'b1;
      addr = tbl[i].addr;
      sb.push_back({tbl[i].exy, tbl[i].eyx});
      tick();
      rqs_strobe = 1'b0;
      e = sb.pop_front();
      chk($sformatf("tbl%0d_xy", i), vec_xy, e[9:5]);
      chk($sformatf("tbl%0d_yx", i), vec_yx, e[4:0]);
      chk($sformatf("tbl%0d_busy", i), {4'b0, busy_xy}, 5'd1);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      chk($sformatf("tbl%0d_clr", i), vec_xy, 5'b0);
      chk($sformatf("tbl%0d_idle", i), {4'b0, busy_yx}, 5'd0);
    end

    // Hold for 5 cycles without ack, then release
    rqs_strobe = 1'b1; addr = 8'h15;
    tick();
    rqs_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), vec_xy, 5'b00010);
      tick();
    end
    arb_ack = 1'b1;
    tick();
    arb_ack = 1'b0;
    chk("hold_release", vec_xy, 5'b0);

    // arb_ack in IDLE is ignored
    arb_ack = 1'b1;
    tick();
    arb_ack = 1'b0;
    chk("ack_idle_busy", {4'b0, busy_xy}, 5'd0);

    // Back-to-back acceptance
    rqs_strobe = 1'b1; addr = 8'h15;
    tick();
    chk("b2b_first", vec_xy, 5'b00010);
    arb_ack = 1'b1; addr = 8'h30;
    tick();
    arb_ack = 1'b0; rqs_strobe = 1'b0;
    chk("b2b_vec", vec_xy, 5'b00100);
    chk("b2b_busy", {4'b0, busy_xy}, 5'd1);
    chk("b2b_ovr", {4'b0, ovr_xy}, 5'd0);
    arb_ack = 1'b1;
    tick();
    arb_ack = 1'b0;
    chk("b2b_done", {4'b0, busy_xy}, 5'd0);

    // Overrun: strobe while waiting
    rqs_strobe = 1'b1; addr = 8'h15;
    tick();
    addr = 8'h30;
    tick();
    rqs_strobe = 1'b0;
    chk("ovr_pulse", {4'b0, ovr_xy}, 5'd1);
    chk("ovr_vec", vec_xy, 5'b00010);
    tick();
    chk("ovr_once", {4'b0, ovr_xy}, 5'd0);
    chk("ovr_vec_kept", vec_xy, 5'b00010);
    arb_ack = 1'b1;
    tick();
    arb_ack = 1'b0;
    chk("ovr_after_ack", {4'b0, busy_xy}, 5'd0);

    // Asynchronous reset mid-request, observed before the next clock edge
    rqs_strobe = 1'b1; addr = 8'h15;
    tick();
    rqs_strobe = 1'b0;
    chk("arst_pre", vec_xy, 5'b00010);
    #2 rst = 1'b0;
    #1;
    chk("arst_vec", vec_xy, 5'b0);
    chk("arst_busy", {4'b0, busy_xy}, 5'd0);
    #1 rst = 1'b1;
    tick();
    chk("arst_stay_idle", {4'b0, busy_xy}, 5'd0);

    // Adaptive: X and Y both productive (E / N)
    port_free = 4'b0100;
    rqs_strobe = 1'b1; addr = 8'h35;
    tick();
    rqs_strobe = 1'b0;
`ifdef RGU_ADAPTIVE_EN
    exp_ad = 5'b01000;
`else
    exp_ad = 5'b00010;
`endif
    chk("adapt_n", vec_xy, exp_ad);
    port_free = 4'b0001;
    tick();
    chk("adapt_e", vec_xy, 5'b00010);
    port_free = 4'b1111;
    arb_ack = 1'b1;
    tick();
    arb_ack = 1'b0;
    chk("adapt_done", vec_xy, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
